// File: rtl/simple_cpu_pkg.sv
// rtl/simple_cpu_pkg.sv - shared types and instruction field offsets for simple_cpu_mc
package simple_cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADDI  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        FN_ADD = 4'd0,
        FN_SUB = 4'd1,
        FN_AND = 4'd2,
        FN_OR  = 4'd3,
        FN_XOR = 4'd4
    } funct_t;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 4;

    // Fields packed MSB first: op, X1, X2, X3, imm, funct
    function automatic int x3_lsb(input int reg_bits, input int data_width);
        return IMM_LSB + data_width + 0 * reg_bits;
    endfunction

    function automatic int x2_lsb(input int reg_bits, input int data_width);
        return x3_lsb(reg_bits, data_width) + reg_bits;
    endfunction

    function automatic int x1_lsb(input int reg_bits, input int data_width);
        return x2_lsb(reg_bits, data_width) + reg_bits;
    endfunction

    function automatic int op_lsb(input int reg_bits, input int data_width);
        return x1_lsb(reg_bits, data_width) + reg_bits;
    endfunction

    function automatic int instr_width(input int reg_bits, input int data_width);
        return op_lsb(reg_bits, data_width) + 2;
    endfunction

endpackage

// File: rtl/simple_cpu_mc_if.sv
// rtl/simple_cpu_mc_if.sv - instruction/retire/debug bus of simple_cpu_mc (flag outputs under CPU_FLAGS_EN)
interface simple_cpu_mc_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2,
    parameter int DATA_WIDTH  = 8
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   retire_valid;
    logic                   retire_illegal;
    logic [REG_BITS-1:0]    dbg_sel;
    logic [DATA_WIDTH-1:0]  dbg_data;
`ifdef CPU_FLAGS_EN
    logic                   flag_z;
    logic                   flag_c;

    modport master (
        output instr, instr_valid, dbg_sel,
        input  instr_ready, retire_valid, retire_illegal, dbg_data, flag_z, flag_c
    );

    modport slave (
        input  instr, instr_valid, dbg_sel,
        output instr_ready, retire_valid, retire_illegal, dbg_data, flag_z, flag_c
    );
`else
    modport master (
        output instr, instr_valid, dbg_sel,
        input  instr_ready, retire_valid, retire_illegal, dbg_data
    );

    modport slave (
        input  instr, instr_valid, dbg_sel,
        output instr_ready, retire_valid, retire_illegal, dbg_data
    );
`endif
endinterface

// File: rtl/simple_cpu_mc_alu.sv
// rtl/simple_cpu_mc_alu.sv - combinational ALU (cpu_alu) returning result and carry/borrow
module cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  funct_t                funct,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);
    // The extra MSB holds carry-out on ADD and borrow on SUB
    logic [DATA_WIDTH:0] wide;

    always_comb begin
        wide = '0;
        case (funct)
            FN_ADD:  wide = {1'b0, a} + {1'b0, b};
            FN_SUB:  wide = {1'b0, a} - {1'b0, b};
            FN_AND:  wide = {1'b0, a & b};
            FN_OR:   wide = {1'b0, a | b};
            FN_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
    end
endmodule

// File: rtl/simple_cpu_mc.sv
// rtl/simple_cpu_mc.sv - multi-cycle CPU core with register file and data memory; flags under CPU_FLAGS_EN
module simple_cpu_mc
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    simple_cpu_mc_if.slave   bus
);
    localparam int NREG = 2 ** REG_BITS;
    localparam int NMEM = 2 ** ADDR_BITS;
    localparam int OP_L = op_lsb(REG_BITS, DATA_WIDTH);
    localparam int X1_L = x1_lsb(REG_BITS, DATA_WIDTH);
    localparam int X2_L = x2_lsb(REG_BITS, DATA_WIDTH);
    localparam int X3_L = x3_lsb(REG_BITS, DATA_WIDTH);

    if (INSTR_WIDTH != instr_width(REG_BITS, DATA_WIDTH)) begin : g_bad_width
        $error("simple_cpu_mc: INSTR_WIDTH must equal 2+3*REG_BITS+DATA_WIDTH+4");
    end

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]  st_data_q, st_data_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [DATA_WIDTH-1:0]  ld_data_q, ld_data_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   carry_q, carry_d;
    logic                   illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]  regs_q [NREG];
    logic [DATA_WIDTH-1:0]  regs_d [NREG];
    logic [DATA_WIDTH-1:0]  mem_q  [NMEM];
    logic [DATA_WIDTH-1:0]  mem_d  [NMEM];
`ifdef CPU_FLAGS_EN
    logic                   flag_z_q, flag_z_d;
    logic                   flag_c_q, flag_c_d;
`endif

    op_t                    op;
    logic [REG_BITS-1:0]    x1, x2, x3;
    logic [DATA_WIDTH-1:0]  imm;
    logic [3:0]             funct_bits;
    funct_t                 alu_fn;
    logic [DATA_WIDTH-1:0]  alu_result;
    logic                   alu_carry;

    assign op         = op_t'(instr_q[OP_L +: 2]);
    assign x1         = instr_q[X1_L +: REG_BITS];
    assign x2         = instr_q[X2_L +: REG_BITS];
    assign x3         = instr_q[X3_L +: REG_BITS];
    assign imm        = instr_q[IMM_LSB +: DATA_WIDTH];
    assign funct_bits = instr_q[FUNCT_LSB +: 4];
    // ADDI, LOAD and STORE all reuse the ALU adder for X2+imm
    assign alu_fn     = (op == OP_ALU) ? funct_t'(funct_bits) : FN_ADD;

    cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .funct  (alu_fn),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        st_data_d = st_data_q;
        result_d  = result_q;
        ld_data_d = ld_data_q;
        addr_d    = addr_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        regs_d    = regs_q;
        mem_d     = mem_q;
`ifdef CPU_FLAGS_EN
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_a_d    = regs_q[x2];
                op_b_d    = (op == OP_ALU) ? regs_q[x3] : imm;
                st_data_d = regs_q[x1];
                illegal_d = (op == OP_ALU) && (funct_bits > 4'd4);
                state_d   = illegal_d ? WB : EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                addr_d   = ADDR_BITS'(alu_result);
                state_d  = (op == OP_LOAD || op == OP_STORE) ? MEM : WB;
            end
            MEM: begin
                if (op == OP_STORE) begin
                    mem_d[addr_q] = st_data_q;
                end else begin
                    ld_data_d = mem_q[addr_q];
                end
                state_d = WB;
            end
            WB: begin
                if (!illegal_q && op != OP_STORE) begin
                    regs_d[x1] = (op == OP_LOAD) ? ld_data_q : result_q;
                end
`ifdef CPU_FLAGS_EN
                if (!illegal_q && (op == OP_ADDI || op == OP_ALU)) begin
                    flag_z_d = (result_q == '0);
                    flag_c_d = carry_q;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            st_data_q <= '0;
            result_q  <= '0;
            ld_data_q <= '0;
            addr_q    <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < NMEM; i++) mem_q[i] <= '0;
`ifdef CPU_FLAGS_EN
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            st_data_q <= st_data_d;
            result_q  <= result_d;
            ld_data_q <= ld_data_d;
            addr_q    <= addr_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            regs_q    <= regs_d;
            mem_q     <= mem_d;
`ifdef CPU_FLAGS_EN
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
`endif
        end
    end

    assign bus.instr_ready    = (state_q == IDLE);
    assign bus.retire_valid   = (state_q == WB);
    assign bus.retire_illegal = (state_q == WB) && illegal_q;
    assign bus.dbg_data       = regs_q[bus.dbg_sel];
`ifdef CPU_FLAGS_EN
    assign bus.flag_z         = flag_z_q;
    assign bus.flag_c         = flag_c_q;
`endif
endmodule
